// File: rtl/kf8237_pkg.sv
// kf8237_pkg: shared types for the KF8237 DMA arbiter.
//   NUM_CHANNELS - number of DMA channels (4)
//   channel_t    - channel index type
//   state_t      - arbiter FSM states
//   onehot()     - channel index to one-hot channel vector
package kf8237_pkg;

    localparam int NUM_CHANNELS = 4;

    typedef logic [1:0] channel_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_REQ,
        GRANT,
        RELEASE
    } state_t;

    function automatic logic [NUM_CHANNELS-1:0] onehot(input channel_t ch);
        return NUM_CHANNELS'(1) << ch;
    endfunction

endpackage

// File: rtl/kf8237_dma_arbiter_if.sv
// kf8237_dma_arbiter_if: DREQ/HRQ/HLDA/DACK handshake bundle of the DMA arbiter.
//   dma_request      - raw DREQ pins, channels 0..3
//   hold_acknowledge - HLDA from the CPU
//   transfer_done    - one-cycle pulse: service of the active channel finished
//   hold_request     - HRQ to the CPU
//   dma_acknowledge  - DACK pins (polarity programmable)
//   active_channel   - granted channel index
//   channel_valid    - high while a channel is granted
//   request_status   - effective pending requests
// Modports: master = arbiter side, slave = CPU / timing-logic side.
interface kf8237_dma_arbiter_if;
    import kf8237_pkg::*;

    logic [NUM_CHANNELS-1:0] dma_request;
    logic                    hold_acknowledge;
    logic                    transfer_done;
    logic                    hold_request;
    logic [NUM_CHANNELS-1:0] dma_acknowledge;
    channel_t                active_channel;
    logic                    channel_valid;
    logic [NUM_CHANNELS-1:0] request_status;

    modport master (
        input  dma_request, hold_acknowledge, transfer_done,
        output hold_request, dma_acknowledge, active_channel, channel_valid, request_status
    );

    modport slave (
        output dma_request, hold_acknowledge, transfer_done,
        input  hold_request, dma_acknowledge, active_channel, channel_valid, request_status
    );

endinterface

// File: rtl/kf8237_priority_pick.sv
// kf8237_priority_pick: combinational channel selection.
//   eff               in  effective request vector
//   rotating_priority in  0 = ch0 highest .. ch3 lowest, 1 = rotate after last_serviced
//   last_serviced     in  channel most recently serviced to completion
//   winner            out highest-ranked requesting channel (0 when none)
//   any_request       out at least one channel requesting
module kf8237_priority_pick
    import kf8237_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] eff,
    input  logic                    rotating_priority,
    input  channel_t                last_serviced,
    output channel_t                winner,
    output logic                    any_request
);

    channel_t start;
    channel_t idx;
    logic     found;

    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        start  = rotating_priority ? channel_t'(last_serviced + channel_t'(1)) : '0;
        // 2-bit index arithmetic wraps 3 -> 0 for free.
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = channel_t'(start + channel_t'(i));
            if (!found && eff[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any_request = |eff;
    end

endmodule

// File: rtl/kf8237_dma_arbiter.sv
// kf8237_dma_arbiter: DREQ synchroniser, priority arbitration and HRQ/HLDA/DACK
// sequencing for a 4-channel 8237-style DMA controller.
//   clock                  in  system clock, rising edge
//   reset                  in  synchronous, active-high
//   dreq_sense_active_low  in  1 = DREQ pins active low
//   dack_sense_active_high in  1 = DACK pins active high
//   rotating_priority      in  0 = fixed, 1 = rotating priority
//   controller_disable     in  blocks new arbitration only
//   mask_register          in  1 = hardware request of channel masked
//   request_register       in  software requests (not maskable)
//   bus                    master modport of kf8237_dma_arbiter_if
module kf8237_dma_arbiter
    import kf8237_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dreq_sense_active_low,
    input  logic                    dack_sense_active_high,
    input  logic                    rotating_priority,
    input  logic                    controller_disable,
    input  logic [NUM_CHANNELS-1:0] mask_register,
    input  logic [NUM_CHANNELS-1:0] request_register,
    kf8237_dma_arbiter_if.master    bus
);

    state_t                  state;
    logic [NUM_CHANNELS-1:0] dreq_sync;
    logic [NUM_CHANNELS-1:0] eff;
    logic [NUM_CHANNELS-1:0] dack_onehot;
    channel_t                winner_q;
    channel_t                last_serviced;
    channel_t                pick;
    logic                    any_request;
    logic                    hrq_q;
    logic                    valid_q;

    assign eff = ((dreq_sync ^ {NUM_CHANNELS{dreq_sense_active_low}}) & ~mask_register)
                 | request_register;

    kf8237_priority_pick u_pick (
        .eff               (eff),
        .rotating_priority (rotating_priority),
        .last_serviced     (last_serviced),
        .winner            (pick),
        .any_request       (any_request)
    );

    // DACK is held as an active-high one-hot vector; the pin polarity is applied
    // on the way out so all four inactive bits follow the programmed sense.
    assign bus.dma_acknowledge = dack_sense_active_high ? dack_onehot : ~dack_onehot;
    assign bus.hold_request    = hrq_q;
    assign bus.active_channel  = winner_q;
    assign bus.channel_valid   = valid_q;
    assign bus.request_status  = eff;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            dreq_sync     <= '0;
            winner_q      <= '0;
            last_serviced <= channel_t'(NUM_CHANNELS - 1);
            hrq_q         <= 1'b0;
            valid_q       <= 1'b0;
            dack_onehot   <= '0;
        end else begin
            dreq_sync <= bus.dma_request;

            unique case (state)
                IDLE: begin
                    if (!controller_disable && any_request) begin
                        winner_q <= pick;
                        hrq_q    <= 1'b1;
                        state    <= HOLD_REQ;
                    end
                end

                HOLD_REQ: begin
                    // The latched winner is kept; a withdrawn request restarts
                    // arbitration from IDLE rather than switching channels here.
                    if (!eff[winner_q]) begin
                        hrq_q <= 1'b0;
                        state <= IDLE;
                    end else if (bus.hold_acknowledge) begin
                        dack_onehot <= onehot(winner_q);
                        valid_q     <= 1'b1;
                        state       <= GRANT;
                    end
                end

                GRANT: begin
                    if (bus.transfer_done) begin
                        hrq_q         <= 1'b0;
                        dack_onehot   <= '0;
                        valid_q       <= 1'b0;
                        last_serviced <= winner_q;
                        state         <= RELEASE;
                    end else if (!bus.hold_acknowledge) begin
                        // CPU took the bus back mid-service: the channel does not
                        // count as serviced, so rotation is left where it was.
                        hrq_q       <= 1'b0;
                        dack_onehot <= '0;
                        valid_q     <= 1'b0;
                        state       <= IDLE;
                    end
                end

                RELEASE: begin
                    if (!bus.hold_acknowledge) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
